// File: rtl/axis_dly_pkg.sv
// Shared helpers, default sizes and the beat layout for the AXI4-Stream delay line.
package axis_dly_pkg;

    localparam int DEF_DATA_W    = 256;
    localparam int DEF_USER_W    = 128;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_MAX_DELAY = 255;
    localparam int DEF_CNT_W     = 32;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Countdown width for a maximum delay; occupancy width for a storage depth.
    function automatic int dly_w_of(input int max_delay);
        return clog2(max_delay + 1);
    endfunction

    function automatic int lvl_w_of(input int depth);
        return clog2(depth + 1);
    endfunction

    // Beat layout at the default widths; the top mirrors it at its own widths.
    typedef struct packed {
        logic [DEF_DATA_W-1:0]   tdata;
        logic [DEF_DATA_W/8-1:0] tstrb;
        logic [DEF_USER_W-1:0]   tuser;
        logic                    tlast;
    } axis_dly_entry_t;

endpackage

// File: rtl/axis_dly_fifo.sv
// Synchronous FIFO with registered level, full/empty flags and exposed pointers.
module axis_dly_fifo
    import axis_dly_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PTR_W = clog2(DEPTH),
    localparam int LVL_W = lvl_w_of(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
        else if (do_pop && !do_push) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset: the pointers alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o  = mem_q[rd_ptr_q];
    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign level_o  = level_q;

endmodule

// File: rtl/axis_delay_line.sv
// AXI4-Stream delay line: each beat is held cfg_delay cycles then released in FIFO order.
// Statistics counters are built only when AXIS_DLY_STATS_EN is defined.
module axis_delay_line
    import axis_dly_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int USER_W    = DEF_USER_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_DELAY = DEF_MAX_DELAY,
    parameter int CNT_W     = DEF_CNT_W,
    localparam int DLY_W    = dly_w_of(MAX_DELAY),
    localparam int LVL_W    = lvl_w_of(DEPTH)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_W-1:0]     S_AXIS_TDATA,
    input  logic [DATA_W/8-1:0]   S_AXIS_TSTRB,
    input  logic [USER_W-1:0]     S_AXIS_TUSER,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic                  S_AXIS_TLAST,
    output logic [DATA_W-1:0]     M_AXIS_TDATA,
    output logic [DATA_W/8-1:0]   M_AXIS_TSTRB,
    output logic [USER_W-1:0]     M_AXIS_TUSER,
    output logic                  M_AXIS_TLAST,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    input  logic [DLY_W-1:0]      cfg_delay,
    output logic [LVL_W-1:0]      level,
    output logic [CNT_W-1:0]      stat_beats,
    output logic [CNT_W-1:0]      stat_pkts,
    output logic [CNT_W-1:0]      stat_stalls,
    output logic [LVL_W-1:0]      stat_max_level,
    input  logic                  stat_clr
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [STRB_W-1:0] tstrb;
        logic [USER_W-1:0] tuser;
        logic              tlast;
    } entry_t;

    entry_t           wr_entry, head_entry;
    logic             push, pop, full, empty, head_ripe;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [DLY_W-1:0] load_val;
    logic [DLY_W-1:0] cnt_q [DEPTH];
    logic [DLY_W-1:0] cnt_d [DEPTH];

    assign wr_entry.tdata = S_AXIS_TDATA;
    assign wr_entry.tstrb = S_AXIS_TSTRB;
    assign wr_entry.tuser = S_AXIS_TUSER;
    assign wr_entry.tlast = S_AXIS_TLAST;

    // Ready depends only on registered occupancy, never on M_AXIS_TREADY.
    assign S_AXIS_TREADY = !areset && !full;
    assign push          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;

    axis_dly_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (aclk),
        .rst_i    (areset),
        .push_i   (push),
        .pop_i    (pop),
        .wdata_i  (wr_entry),
        .rdata_o  (head_entry),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr),
        .level_o  (level),
        .full_o   (full),
        .empty_o  (empty)
    );

    generate
        if (MAX_DELAY < (1 << DLY_W) - 1) begin : g_clamp
            assign load_val = (cfg_delay > DLY_W'(MAX_DELAY)) ? DLY_W'(MAX_DELAY) : cfg_delay;
        end else begin : g_no_clamp
            assign load_val = cfg_delay;
        end
    endgenerate

    // Countdowns run freely regardless of egress stalls and stick at zero.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (push && (wr_ptr == PTR_W'(i))) cnt_d[i] = load_val;
            else if (cnt_q[i] != '0)           cnt_d[i] = cnt_q[i] - DLY_W'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Only the head is ever tested, so a ripe later entry cannot overtake it.
    assign head_ripe     = (cnt_q[rd_ptr] == '0);
    assign M_AXIS_TVALID = !empty && head_ripe;
    assign M_AXIS_TDATA  = M_AXIS_TVALID ? head_entry.tdata : '0;
    assign M_AXIS_TSTRB  = M_AXIS_TVALID ? head_entry.tstrb : '0;
    assign M_AXIS_TUSER  = M_AXIS_TVALID ? head_entry.tuser : '0;
    assign M_AXIS_TLAST  = M_AXIS_TVALID && head_entry.tlast;

`ifdef AXIS_DLY_STATS_EN
    logic [CNT_W-1:0] beats_q, pkts_q, stalls_q;
    logic [LVL_W-1:0] max_lvl_q;

    always_ff @(posedge aclk) begin
        if (areset || stat_clr) begin
            beats_q   <= '0;
            pkts_q    <= '0;
            stalls_q  <= '0;
            max_lvl_q <= '0;
        end else begin
            if (pop)                 beats_q  <= beats_q + CNT_W'(1);
            if (pop && M_AXIS_TLAST) pkts_q   <= pkts_q + CNT_W'(1);
            if (M_AXIS_TVALID && !M_AXIS_TREADY) stalls_q <= stalls_q + CNT_W'(1);
            if (level > max_lvl_q)   max_lvl_q <= level;
        end
    end

    assign stat_beats     = beats_q;
    assign stat_pkts      = pkts_q;
    assign stat_stalls    = stalls_q;
    assign stat_max_level = max_lvl_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_beats      = '0;
    assign stat_pkts       = '0;
    assign stat_stalls     = '0;
    assign stat_max_level  = '0;
`endif

endmodule
